// File: rtl/gshare_pkg.sv
// Shared constants and helpers for the gshare branch predictor.
// Build option: define GSHARE_HASH_EN for PC^GHR indexing; otherwise bimodal (PC only).
package gshare_pkg;

   localparam int unsigned GSHARE_N_DEF  = 2;
   localparam int unsigned GSHARE_K_DEF  = 4;
   localparam int unsigned GSHARE_PC_W   = 32;
   localparam int unsigned GSHARE_PC_OFS = 2;

   // Weakly not-taken counter value for an n-bit counter: 2^(n-1)-1.
   function automatic logic [31:0] ctr_rst_val(input int unsigned n);
      return 32'((32'd1 << (n - 1)) - 32'd1);
   endfunction

endpackage

// File: rtl/pht_counter_next.sv
// Saturating up/down next-value logic for one pattern-history counter.
module pht_counter_next #(
   parameter int unsigned N = 2
) (
   input  logic [N-1:0] ctr_i,
   input  logic         taken_i,
   output logic [N-1:0] ctr_nxt_c
);

   localparam logic [N-1:0] CTR_MAX = '1;
   localparam logic [N-1:0] CTR_MIN = '0;

   // Increment on taken, decrement on not-taken, holding at the rails.
   always_comb begin
      ctr_nxt_c = ctr_i;
      if (taken_i) begin
         if (ctr_i != CTR_MAX) ctr_nxt_c = ctr_i + N'(1);
      end else begin
         if (ctr_i != CTR_MIN) ctr_nxt_c = ctr_i - N'(1);
      end
   end

endmodule

// File: rtl/gshare_pred.sv
// Gshare branch direction predictor: 2^K saturating counters, global history,
// one-cycle registered prediction, resolution-time training and GHR recovery.
// Build option: GSHARE_HASH_EN selects PC^GHR indexing; undefined gives PC-only indexing.
module gshare_pred
   import gshare_pkg::*;
#(
   parameter int unsigned N = GSHARE_N_DEF,
   parameter int unsigned K = GSHARE_K_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   lookup_valid,
   input  logic [GSHARE_PC_W-1:0] lookup_pc,
   output logic                   pred_valid,
   output logic                   pred_taken,
   output logic [K-1:0]           pred_ghr,
   input  logic                   update_valid,
   input  logic [GSHARE_PC_W-1:0] update_pc,
   input  logic                   update_taken,
   input  logic                   update_mispredict,
   input  logic [K-1:0]           update_ghr
);

   localparam int unsigned  DEPTH   = 1 << K;
   localparam logic [N-1:0] CTR_RST = N'(ctr_rst_val(N));

   logic [N-1:0] pht_q [DEPTH];
   logic [K-1:0] ghr_q, ghr_d;
   logic         pred_valid_q, pred_valid_d;
   logic         pred_taken_q, pred_taken_d;
   logic [K-1:0] pred_ghr_q, pred_ghr_d;

   logic [K-1:0] lk_idx, up_idx;
   logic [N-1:0] lk_ctr, up_ctr, up_ctr_nxt;

   // Table index formation for the lookup and update ports.
`ifdef GSHARE_HASH_EN
   assign lk_idx = lookup_pc[GSHARE_PC_OFS +: K] ^ ghr_q;
   assign up_idx = update_pc[GSHARE_PC_OFS +: K] ^ update_ghr;
`else
   assign lk_idx = lookup_pc[GSHARE_PC_OFS +: K];
   assign up_idx = update_pc[GSHARE_PC_OFS +: K];
`endif

   // Reads see the registered table, so a same-cycle update is not visible yet.
   assign lk_ctr = pht_q[lk_idx];
   assign up_ctr = pht_q[up_idx];

   pht_counter_next #(.N(N)) u_ctr_next (
      .ctr_i     (up_ctr),
      .taken_i   (update_taken),
      .ctr_nxt_c (up_ctr_nxt)
   );

   // Next-state for history and prediction outputs; recovery overrides speculation.
   always_comb begin
      ghr_d        = ghr_q;
      pred_valid_d = 1'b0;
      pred_taken_d = pred_taken_q;
      pred_ghr_d   = pred_ghr_q;
      if (lookup_valid) begin
         pred_valid_d = 1'b1;
         pred_taken_d = lk_ctr[N-1];
         pred_ghr_d   = ghr_q;
         ghr_d        = {ghr_q[K-2:0], lk_ctr[N-1]};
      end
      if (update_valid && update_mispredict) begin
         ghr_d = {update_ghr[K-2:0], update_taken};
      end
   end

   // State registers with synchronous active-low reset dominating all traffic.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pht_q        <= '{default: CTR_RST};
         ghr_q        <= '0;
         pred_valid_q <= 1'b0;
         pred_taken_q <= 1'b0;
         pred_ghr_q   <= '0;
      end else begin
         if (update_valid) pht_q[up_idx] <= up_ctr_nxt;
         ghr_q        <= ghr_d;
         pred_valid_q <= pred_valid_d;
         pred_taken_q <= pred_taken_d;
         pred_ghr_q   <= pred_ghr_d;
      end
   end

   assign pred_valid = pred_valid_q;
   assign pred_taken = pred_taken_q;
   assign pred_ghr   = pred_ghr_q;

   // PC bits outside the index field and the history MSB on recovery are not needed.
   logic unused_bits;
   assign unused_bits = ^{lookup_pc[GSHARE_PC_W-1:K+GSHARE_PC_OFS],
                          lookup_pc[GSHARE_PC_OFS-1:0],
                          update_pc[GSHARE_PC_W-1:K+GSHARE_PC_OFS],
                          update_pc[GSHARE_PC_OFS-1:0],
                          update_ghr[K-1]};

endmodule

// File: tb/tb_gshare_pred.sv
// Directed table-driven bench for gshare_pred (default build, N=2, K=4).
module tb_gshare_pred;

   logic        clk = 1'b0;
   logic        reset;
   logic        lookup_valid;
   logic [31:0] lookup_pc;
   logic        pred_valid;
   logic        pred_taken;
   logic [3:0]  pred_ghr;
   logic        update_valid;
   logic [31:0] update_pc;
   logic        update_taken;
   logic        update_mispredict;
   logic [3:0]  update_ghr;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   gshare_pred #(.N(2), .K(4)) dut (
      .clk               (clk),
      .reset             (reset),
      .lookup_valid      (lookup_valid),
      .lookup_pc         (lookup_pc),
      .pred_valid        (pred_valid),
      .pred_taken        (pred_taken),
      .pred_ghr          (pred_ghr),
      .update_valid      (update_valid),
      .update_pc         (update_pc),
      .update_taken      (update_taken),
      .update_mispredict (update_mispredict),
      .update_ghr        (update_ghr)
   );

   typedef struct {
      logic        lv;
      logic [31:0] lpc;
      logic        uv;
      logic [31:0] upc;
      logic        ut;
      logic        um;
      logic [3:0]  ughr;
      logic        epv;
      logic        ept;
      logic [3:0]  epg;
   } vec_t;

   localparam int NV = 28;
   vec_t vecs [NV];

   function automatic vec_t mk(input logic lv, input logic [31:0] lpc,
                               input logic uv, input logic [31:0] upc,
                               input logic ut, input logic um, input logic [3:0] ughr,
                               input logic epv, input logic ept, input logic [3:0] epg);
      vec_t v;
      v.lv = lv; v.lpc = lpc; v.uv = uv; v.upc = upc; v.ut = ut; v.um = um;
      v.ughr = ughr; v.epv = epv; v.ept = ept; v.epg = epg;
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      lookup_valid      = v.lv;
      lookup_pc         = v.lpc;
      update_valid      = v.uv;
      update_pc         = v.upc;
      update_taken      = v.ut;
      update_mispredict = v.um;
      update_ghr        = v.ughr;
   endtask

   task automatic expect_out(input string tag, input logic pv, input logic pt, input logic [3:0] pg);
      check({tag, ".pred_valid"}, int'(pred_valid), int'(pv));
      check({tag, ".pred_taken"}, int'(pred_taken), int'(pt));
      check({tag, ".pred_ghr"},   int'(pred_ghr),   int'(pg));
   endtask

   initial begin
      //                lv    lpc     uv   upc     ut   um   ughr     epv  ept  epg
      vecs[0]  = mk(1'b1, 32'h40, 1'b0, 32'h0,  1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000);
      vecs[1]  = mk(1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
      vecs[2]  = mk(1'b0, 32'h0,  1'b1, 32'h40, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
      vecs[3]  = mk(1'b0, 32'h0,  1'b1, 32'h40, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
      vecs[4]  = mk(1'b0, 32'h0,  1'b1, 32'h40, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
      vecs[5]  = mk(1'b1, 32'h40, 1'b0, 32'h0,  1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000);
      vecs[6]  = mk(1'b1, 32'h40, 1'b0, 32'h0,  1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 4'b0001);
      vecs[7]  = mk(1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0001);
      vecs[8]  = mk(1'b0, 32'h0,  1'b1, 32'h44, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0001);
      vecs[9]  = mk(1'b0, 32'h0,  1'b1, 32'h44, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0001);
      vecs[10] = mk(1'b1, 32'h44, 1'b0, 32'h0,  1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0011);
      vecs[11] = mk(1'b0, 32'h0,  1'b1, 32'h44, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0011);
      vecs[12] = mk(1'b1, 32'h44, 1'b0, 32'h0,  1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0110);
      vecs[13] = mk(1'b0, 32'h0,  1'b1, 32'h44, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0110);
      vecs[14] = mk(1'b1, 32'h44, 1'b0, 32'h0,  1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 4'b1100);
      vecs[15] = mk(1'b0, 32'h0,  1'b1, 32'h40, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b1100);
      vecs[16] = mk(1'b1, 32'h40, 1'b0, 32'h0,  1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 4'b1001);
      vecs[17] = mk(1'b0, 32'h0,  1'b1, 32'h40, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b1001);
      vecs[18] = mk(1'b1, 32'h40, 1'b0, 32'h0,  1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0011);
      vecs[19] = mk(1'b0, 32'h0,  1'b1, 32'h48, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b0, 4'b0011);
      vecs[20] = mk(1'b1, 32'h40, 1'b1, 32'h4C, 1'b1, 1'b1, 4'b0011, 1'b1, 1'b0, 4'b0101);
      vecs[21] = mk(1'b1, 32'h40, 1'b0, 32'h0,  1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0111);
      vecs[22] = mk(1'b1, 32'h40, 1'b0, 32'h0,  1'b1, 1'b1, 4'b1111, 1'b1, 1'b0, 4'b1110);
      vecs[23] = mk(1'b1, 32'h40, 1'b0, 32'h0,  1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b1100);
      vecs[24] = mk(1'b1, 32'h54, 1'b1, 32'h54, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b1000);
      vecs[25] = mk(1'b1, 32'h54, 1'b0, 32'h0,  1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000);
      vecs[26] = mk(1'b0, 32'h0,  1'b1, 32'h58, 1'b0, 1'b1, 4'b1011, 1'b0, 1'b1, 4'b0000);
      vecs[27] = mk(1'b1, 32'h58, 1'b0, 32'h0,  1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0110);

      // Reset with a lookup pending: no prediction may emerge.
      reset = 1'b0;
      drive(mk(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000));
      repeat (2) @(posedge clk);
      #1;
      expect_out("reset", 1'b0, 1'b0, 4'b0000);
      drive(mk(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000));
      reset = 1'b1;

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i]);
         @(posedge clk);
         #1;
         expect_out($sformatf("vec%0d", i), vecs[i].epv, vecs[i].ept, vecs[i].epg);
      end

      // Mid-stream reset dominating a same-cycle lookup and taken update.
      reset = 1'b0;
      drive(mk(1'b1, 32'h54, 1'b1, 32'h54, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000));
      @(posedge clk);
      #1;
      expect_out("midrst", 1'b0, 1'b0, 4'b0000);
      reset = 1'b1;

      // Trained counters (idx5=2, idx1=2) must read back weakly not-taken, GHR cleared.
      drive(mk(1'b1, 32'h54, 1'b0, 32'h0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000));
      @(posedge clk);
      #1;
      expect_out("post_rst_idx5", 1'b1, 1'b0, 4'b0000);
      drive(mk(1'b1, 32'h44, 1'b0, 32'h0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000));
      @(posedge clk);
      #1;
      expect_out("post_rst_idx1", 1'b1, 1'b0, 4'b0000);
      drive(mk(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000));
      @(posedge clk);
      #1;
      expect_out("post_rst_idle", 1'b0, 1'b0, 4'b0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gshare_pred.md
GSHARE_PRED -- requirements
Module: gshare_pred

Interface
REQ-001 Parameter N, default 2: width of each saturating counter, N >= 2.
REQ-002 Parameter K, default 4: index and history width; table holds 2^K counters; K >= 2.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-005 lookup_valid  input  1  fetch requests a prediction this cycle.
REQ-006 lookup_pc  input  32  PC of the branch being fetched.
REQ-007 pred_valid  output  1  registered; high exactly one cycle after an accepted lookup.
REQ-008 pred_taken  output  1  registered prediction, MSB of the selected counter.
REQ-009 pred_ghr  output  K  registered GHR value used to form the lookup index; returned later on update.
REQ-010 update_valid  input  1  branch resolved this cycle.
REQ-011 update_pc  input  32  PC of the resolved branch.
REQ-012 update_taken  input  1  actual outcome.
REQ-013 update_mispredict  input  1  resolved outcome differs from the prediction; ignored unless update_valid.
REQ-014 update_ghr  input  K  pred_ghr snapshot that accompanied the resolved branch.

Function
REQ-015 Lookup index SHALL be lookup_pc[K+1:2] XOR GHR; update index SHALL be update_pc[K+1:2] XOR update_ghr.
REQ-016 Lookup latency SHALL be 1 cycle: pred_valid, pred_taken and pred_ghr reflect the lookup of the previous cycle; when lookup_valid is low, pred_valid SHALL be 0 and pred_taken/pred_ghr SHALL hold.
REQ-017 Update with update_taken=1 SHALL increment the counter, saturating at 2^N-1.
REQ-018 Update with update_taken=0 SHALL decrement the counter, saturating at 0.
REQ-019 On a lookup without a mispredict update, GHR SHALL shift left, inserting the predicted bit at LSB.
REQ-020 update_valid with update_mispredict SHALL set GHR to {update_ghr[K-2:0], update_taken}, overriding any same-cycle lookup shift.
REQ-021 Same-cycle lookup and update to the same index: the lookup SHALL return the pre-update counter (read-before-write).
REQ-022 A lookup in a mispredict-recovery cycle SHALL use the old GHR for indexing; its pred_ghr SHALL carry that old GHR.
REQ-023 Updates SHALL be accepted every cycle, with no back-pressure; there is no ready signal.

Reset
REQ-024 With reset low at posedge clk: every counter SHALL be 2^(N-1)-1 (weakly not-taken), GHR=0, pred_valid=0, pred_taken=0, pred_ghr=0.
REQ-025 Reset SHALL dominate lookup and update in the same cycle; a lookup pending at reset SHALL produce no pred_valid.

Configuration
REQ-026 Macro GSHARE_HASH_EN defined: indexing per REQ-015.
REQ-027 GSHARE_HASH_EN undefined: the index SHALL be the PC bits only (bimodal); GHR, pred_ghr and recovery SHALL still operate per REQ-019/020.

Structure
REQ-028 Shared package gshare_pkg SHALL hold the defaults for N and K, the PC width (32), the PC index offset (2) and the counter reset-value function.
REQ-029 Sub-module pht_counter_next SHALL compute the saturating next value from (counter, taken); it is instantiated once on the update path.

Verification
REQ-030 Reset, then lookup pc=0x40 -> next cycle pred_valid=1, pred_taken=0, pred_ghr=0; GHR stays 0.
REQ-031 Three updates taken, pc=0x40, ghr=0 -> counter[0x0] 1->2->3->3; a following lookup with GHR=0 -> pred_taken=1.
REQ-032 Update not-taken at counter=0 -> remains 0, no wrap to 3.
REQ-033 GHR=4'b0101; update mispredict, taken=1, update_ghr=4'b0011, plus same-cycle lookup -> GHR=4'b0111, and that lookup's pred_ghr=4'b0101.
REQ-034 Same-cycle lookup and taken update at index 5 with counter=1 -> pred_taken=0, counter becomes 2.
REQ-035 Reset asserted low mid-stream after training -> all counters back to 1, GHR=0, pred_valid=0 next cycle.
